// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and helpers for the RSA datapath blocks
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    // Width of a counter that must hold the value width/k (the number of step groups).
    function automatic int cnt_width(input int width, input int k);
        return $clog2(width / k + 1);
    endfunction

endpackage

// File: rtl/modmult_step.sv
// rtl/modmult_step.sv - one combinational radix-2 Blakley step: r_next = (2r + bit*a) mod n
module modmult_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    input  logic             b_bit,
    output logic [WIDTH-1:0] r_next
);

    logic [WIDTH:0]   n_x;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   u;
    logic [WIDTH-1:0] t_red;

    // With r < n and a < n, one conditional subtract after each add keeps everything below n.
    assign n_x   = {1'b0, n};
    assign t     = {r, 1'b0};
    assign t_red = (t >= n_x) ? WIDTH'(t - n_x) : WIDTH'(t);
    assign u     = {1'b0, t_red} + {1'b0, a};

    assign r_next = !b_bit      ? t_red :
                    (u >= n_x)  ? WIDTH'(u - n_x) : WIDTH'(u);

endmodule

// File: rtl/modmult_radix.sv
// rtl/modmult_radix.sv - interleaved modular multiplier retiring K bits of b per clock
module modmult_radix
    import rsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW    = cnt_width(WIDTH, K);
    localparam int STEPS = WIDTH / K;

    if (WIDTH < 2 || K < 1 || (WIDTH % K) != 0) begin : g_param_check
        $error("modmult_radix: WIDTH must be >= 2 and an integer multiple of K");
    end

    mm_state_t        state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] nreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] chain [0:K];

    // K steps chained per clock, consuming b from its MSB downward.
    assign chain[0] = r;
    for (genvar i = 0; i < K; i++) begin : g_step
        modmult_step #(.WIDTH(WIDTH)) u_step (
            .r      (chain[i]),
            .a      (areg),
            .n      (nreg),
            .b_bit  (breg[WIDTH-1-i]),
            .r_next (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= '0;
            areg   <= '0;
            breg   <= '0;
            nreg   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg <= a;
                        breg <= b;
                        nreg <= n;
                        busy <= 1'b1;
                        if (n == '0 || a >= n || b >= n) begin
                            state  <= DONE;
                            result <= '0;
                            err    <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            state <= CALC;
                            r     <= '0;
                            cnt   <= CW'(STEPS);
                        end
                    end
                end
                CALC: begin
                    r    <= chain[K];
                    breg <= breg << K;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        result <= chain[K];
                        err    <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
